// File: rtl/pool_avg_out.sv
// Average-pooling output stage: aligns the upstream adder-tree sum to its window,
// rounds and saturates it, tags it with a channel index and queues it for the consumer.
module pool_avg_out #(
    parameter int LAT    = 6,
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 16,
    parameter int OUT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      win_start,
    input  logic [15:0]               sum_in,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_last,
    output logic                      overflow
);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int SAT_MAX = (2 ** (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (OUT_W - 1));

    logic [LAT-1:0]     dly;
    logic               cap;
    logic signed [16:0] biased;
    logic signed [16:0] avg_full;
    logic [OUT_W-1:0]   avg_sat;
    logic [CH_W-1:0]    ch_cnt;

    logic               st_valid;
    logic [OUT_W-1:0]   st_data;
    logic [CH_W-1:0]    st_ch;

    logic [OUT_W-1:0]   mem_data [DEPTH];
    logic [CH_W-1:0]    mem_ch   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               pop;
    logic               do_push;

    // Strobe delay line matching the upstream tree latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly <= '0;
        end else begin
            dly <= (dly << 1) | LAT'(win_start);
        end
    end

    assign cap = dly[LAT-1];

    // Round half up: bias by half an LSB of the result, then floor via arithmetic shift
    always_comb begin
        biased   = $signed({sum_in[15], sum_in}) + 17'sd32;
        avg_full = biased >>> 6;
        if (int'(avg_full) > SAT_MAX) begin
            avg_sat = OUT_W'(SAT_MAX);
        end else if (int'(avg_full) < SAT_MIN) begin
            avg_sat = OUT_W'(SAT_MIN);
        end else begin
            avg_sat = OUT_W'(avg_full);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt   <= '0;
            st_valid <= 1'b0;
        end else begin
            st_valid <= cap;
            if (cap) begin
                ch_cnt <= (ch_cnt == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            st_data <= avg_sat;
            st_ch   <= ch_cnt;
        end
    end

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign out_valid = (count != '0);
    assign pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = st_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr] <= st_data;
            mem_ch[wr_ptr]   <= st_ch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (st_valid & full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ch   = out_valid ? mem_ch[rd_ptr] : '0;
    assign out_last = out_valid && (mem_ch[rd_ptr] == CH_W'(NUM_CH - 1));

    assert property (@(posedge clk) disable iff (rst) count <= (PTR_W + 1)'(DEPTH));

endmodule

// File: tb/tb_pool_avg_out.sv
// Self-checking bench for pool_avg_out: upstream tree modelled as a LAT-deep sum queue,
// expected words queued at window issue and compared on each output handshake.
module tb_pool_avg_out;
    localparam int LAT    = 6;
    localparam int DEPTH  = 4;
    localparam int NUM_CH = 16;
    localparam int OUT_W  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        win_start;
    logic [15:0] sum_in;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [3:0]  out_ch;
    logic        out_last;
    logic        overflow;

    pool_avg_out #(.LAT(LAT), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .win_start(win_start), .sum_in(sum_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic signed [7:0] d; logic [3:0] ch; logic last; } exp_t;
    typedef struct { int s; int d; } vec_t;

    exp_t        sb[$];
    logic [15:0] hist[$];
    vec_t        tab[10];
    int ntests = 0, nfail = 0, cyc = 0, model_ch = 0, npops = 0, first_valid = -1;

    task automatic check(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_avg(input int s);
        int a, q;
        a = s + 32;
        q = a / 64;
        if (a < 0 && (a % 64) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // Drives one cycle of inputs, scores any handshake, then advances past the edge
    task automatic step(input logic ws, input logic [15:0] s, input logic rdy);
        exp_t e;
        win_start = ws;
        out_ready = rdy;
        hist.push_back(s);
        sum_in = hist.pop_front();
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && rdy) begin
            npops++;
            if (sb.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                e = sb.pop_front();
                ntests++;
                if (out_data !== e.d || out_ch !== e.ch || out_last !== e.last) begin
                    nfail++;
                    $display("FAIL word: got d=%0d ch=%0d last=%0b expected d=%0d ch=%0d last=%0b",
                             $signed(out_data), out_ch, out_last, e.d, e.ch, e.last);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), rdy);
    endtask

    task automatic win(input int s, input int exp_d, input bit keep, input logic rdy);
        exp_t e;
        e.d    = 8'(exp_d);
        e.ch   = 4'(model_ch);
        e.last = (model_ch == NUM_CH - 1);
        if (keep) sb.push_back(e);
        model_ch = (model_ch + 1) % NUM_CH;
        step(1'b1, 16'(s), rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_overflow", int'(overflow), 0);
        idle(2, 1'b0);
        rst = 1'b0;
        sb.delete();
        model_ch = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tab[0] = '{6400, 100};  tab[1] = '{32, 1};     tab[2] = '{-33, -1};
        tab[3] = '{8191, 127};  tab[4] = '{-8192, -128}; tab[5] = '{-32, 0};
        tab[6] = '{31, 0};      tab[7] = '{95, 1};     tab[8] = '{-97, -2};
        tab[9] = '{32767, 127};

        rst = 1'b1; win_start = 1'b0; out_ready = 1'b0; sum_in = '0;
        repeat (LAT) hist.push_back('0);
        #1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_data", int'(out_data), 0);
        check("reset_ch", int'(out_ch), 0);
        check("reset_last", int'(out_last), 0);
        check("reset_overflow", int'(overflow), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single window: valid LAT+2 cycles after win_start
        cyc = 0; first_valid = -1;
        win(6400, 100, 1, 1'b1);
        idle(12, 1'b1);
        check("latency", first_valid, LAT + 2);

        // Rounding / saturation vectors, back to back
        for (int i = 0; i < 10; i++) win(tab[i].s, tab[i].d, 1, 1'b1);
        idle(12, 1'b1);
        check("table_drained", sb.size(), 0);

        // Full frame plus one wrap
        do_reset();
        for (int i = 0; i < NUM_CH + 1; i++) win(i * 200 - 1600, ref_avg(i * 200 - 1600), 1, 1'b1);
        idle(12, 1'b1);
        check("frame_drained", sb.size(), 0);
        check("frame_overflow", int'(overflow), 0);

        // Backpressure: 6 captures into a 4-deep FIFO
        do_reset();
        for (int i = 0; i < 6; i++) win(1000 * (i + 1), ref_avg(1000 * (i + 1)), i < DEPTH, 1'b0);
        idle(10, 1'b0);
        check("bp_overflow", int'(overflow), 1);
        check("bp_valid", int'(out_valid), 1);
        idle(3, 1'b0);
        check("bp_hold_data", int'($signed(out_data)), 16);
        check("bp_hold_ch", int'(out_ch), 0);
        npops = 0;
        idle(10, 1'b1);
        check("bp_words", npops, DEPTH);
        check("bp_drained", sb.size(), 0);
        win(640, 10, 1, 1'b1);
        idle(12, 1'b1);
        check("bp_next_tag_drained", sb.size(), 0);
        check("bp_overflow_sticky", int'(overflow), 1);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) win(-640 * (i + 1), ref_avg(-640 * (i + 1)), 1, 1'b0);
        idle(10, 1'b0);
        npops = 0;
        win(5000, ref_avg(5000), 1, 1'b0);
        idle(LAT, 1'b0);
        step(1'b0, 16'($urandom), 1'b1);
        idle(4, 1'b0);
        check("full_pushpop_overflow", int'(overflow), 0);
        idle(10, 1'b1);
        check("full_pushpop_words", npops, DEPTH + 1);
        check("full_pushpop_drained", sb.size(), 0);

        // Reset three cycles into a window
        do_reset();
        win(3200, 50, 0, 1'b1);
        idle(2, 1'b1);
        rst = 1'b1;
        idle(1, 1'b1);
        rst = 1'b0;
        sb.delete();
        model_ch = 0;
        first_valid = -1;
        idle(12, 1'b1);
        check("midrst_no_valid", first_valid, -1);
        win(3200, 50, 1, 1'b1);
        idle(12, 1'b1);
        check("midrst_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/pool_avg_out.md
POOL_AVG_OUT -- requirements
Module: pool_avg_out

Interface
REQ-001 Parameter LAT, default 6: cycles from `win_start` to the matching tree sum on `sum_in`.
REQ-002 Parameter DEPTH, default 4: output FIFO entries (power of two, at least 2).
REQ-003 Parameter NUM_CH, default 16: channels per frame, used for tagging.
REQ-004 Parameter OUT_W, default 8: width of the signed averaged output.
REQ-005 `clk`  in  1  sole clock; all state updates on its rising edge.
REQ-006 `rst`  in  1  reset, asynchronous, active-high.
REQ-007 `win_start`  in  1  high for one cycle when a 64-element window enters the upstream adder tree.
REQ-008 `sum_in`  in  16  signed two's-complement wrapped 64-element sum from the upstream tree.
REQ-009 `out_ready`  in  1  consumer can accept an output word this cycle.
REQ-010 `out_valid`  out  1  FIFO head holds a valid word.
REQ-011 `out_data`  out  OUT_W  signed average of the FIFO head.
REQ-012 `out_ch`  out  clog2(NUM_CH)  channel index of the FIFO head.
REQ-013 `out_last`  out  1  FIFO head is channel NUM_CH-1.
REQ-014 `overflow`  out  1  sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-015 A LAT-stage shift register shall delay `win_start`; its final stage is the capture strobe `cap`.
REQ-016 `sum_in` shall be sampled only in a cycle where `cap` is high; it is ignored otherwise.
REQ-017 Average computation: sign-extend `sum_in` to 17 bits, add 32, arithmetic shift right by 6 (round half up toward +inf).
REQ-018 The average shall saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before it is stored.
REQ-019 The average shall be computed in a one-cycle registered stage after `cap`, so a push reaches the FIFO LAT+1 cycles after `win_start`.
REQ-020 With the FIFO empty, `out_valid` shall rise LAT+2 cycles after `win_start`.
REQ-021 A channel counter shall tag every captured sample, counting 0 to NUM_CH-1 and then wrapping to 0.
REQ-022 The channel counter shall advance on every capture, including dropped captures, so that tags stay frame-aligned.
REQ-023 `out_last` shall equal (tag == NUM_CH-1) for the head entry.
REQ-024 Pop shall occur when `out_valid` and `out_ready` are both high.
REQ-025 Push shall occur when the registered stage holds a valid sample.
REQ-026 FIFO full with a push and no pop: the sample is dropped, `overflow` is set, and FIFO contents are unchanged.
REQ-027 FIFO full with a push and a pop in the same cycle: both succeed and the occupancy stays at DEPTH.
REQ-028 FIFO empty with a push in the same cycle: no pop occurs (no bypass), and `out_valid` rises the next cycle.
REQ-029 FIFO order shall be strict first-in first-out.
REQ-030 Read and write pointers shall wrap modulo DEPTH.
REQ-031 The occupancy count shall range from 0 to DEPTH inclusive.
REQ-032 `out_data`, `out_ch` and `out_last` shall hold stable while `out_valid` is high and `out_ready` is low.
REQ-033 Back-to-back `win_start` pulses on consecutive cycles shall be supported, giving one capture per cycle.
REQ-034 `overflow` shall clear only on reset.

Reset
REQ-035 While `rst` is high, the following shall be forced to zero: delay line, registered stage valid, FIFO pointers and count, channel counter, and `overflow`.
REQ-036 While `rst` is high, `out_valid` shall be 0, and `out_data`, `out_ch` and `out_last` shall be 0.
REQ-037 Reset asserted mid-operation shall discard in-flight strobes and stored words; no output follows deassertion until a new `win_start`.
REQ-038 After reset, the first capture shall be tagged channel 0.

Verification
REQ-039 Single window, rounding: `win_start` at cycle 0, `sum_in`=6400 at cycle 6, `out_ready`=1 -> `out_valid` high at cycle 8 with `out_data`=100, `out_ch`=0, `out_last`=0.
REQ-040 Rounding and saturation: sums 32, -33, 8191 and -8192 -> outputs 1, -1, 127 (saturated from 128) and -128.
REQ-041 Full frame: 16 consecutive `win_start` pulses with ascending sums -> 16 in-order outputs with `out_ch` 0..15, `out_last` only on 15; a 17th capture is tagged 0.
REQ-042 Backpressure: `out_ready`=0 and 6 captures -> first 4 stored, `overflow`=1, tags 4 and 5 consumed; after `out_ready`=1 exactly 4 words emerge with tags 0..3.
REQ-043 Simultaneous push and pop at full: FIFO full, `out_ready`=1 during a push -> count stays 4, no overflow, order preserved.
REQ-044 Reset mid-flight: `rst` pulsed 3 cycles after `win_start` -> no `out_valid` afterward; the next window is tagged channel 0.
